sipo_rx: RTL and testbench
==========================

Name: sipo_rx

Overview:
- Deserializer directly downstream of the 75-bit PISO transmitter in the FMA test datapath.
- Collects the MSB-first serial stream, delimited by a start-of-frame strobe, back into 75-bit words.
- Tags each word with its row index (1..ROWS, wrapping).
- Hands words to the consumer through a small valid/ready output buffer with overflow and framing-error reporting.

Parameters:
- WIDTH, 75, bits per serial word.
- ROWS, 4, row-index wrap value; row cycles 1..ROWS.
- DEPTH, 2, output buffer entries; power of two, >=2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the clk rising edge only.
- en  in  1  bit strobe; sin/sof are sampled only when en=1.
- sin  in  1  serial data, MSB first.
- sof  in  1  start of frame; qualifies the current sin as bit WIDTH-1 of a new word.
- dout  out  WIDTH  head-of-buffer word.
- row  out  3  row tag of the head word.
- dvalid  out  1  head entry valid.
- dready  in  1  consumer accept; pop when dvalid&&dready.
- busy  out  1  frame collection in progress (state SHIFT).
- overflow  out  1  sticky; a completed word was dropped because the buffer was full.
- frm_err  out  1  one-cycle pulse; a frame was aborted by an early sof.

Behaviour:
- Reset (rst=0 at a clk edge):
  - shift register, bit counter and buffer pointers cleared; state IDLE.
  - Outputs: dout=0, row=0, dvalid=0, busy=0, overflow=0, frm_err=0.
  - Row tracker = 0.
  - Reset mid-frame discards the partial word and all buffered words.
- Bit counter: width clog2(WIDTH+1); counts bits received in the current frame.
- Row tracker: updated on every accepted sof (en&&sof). Next value is 1 if current==ROWS, else current+1. From reset the first sof gives 1. The tracker value is latched as the frame's tag.
- State IDLE:
  - en&&sof: shift reg <= sin in bit WIDTH-1; count=1; state -> SHIFT; busy=1 next cycle.
  - en&&!sof: bit ignored.
  - en=0: hold.
- State SHIFT:
  - en=0: hold everything.
  - en&&!sof: shift in sin as next lower bit; count+1.
  - When the bit making count==WIDTH arrives (bit 0): word complete; push {word, tag} to the buffer; state -> IDLE.
  - en&&sof before count==WIDTH: partial word discarded; frm_err=1 for one cycle; the new frame starts with this bit (count=1, new row tag); stays in SHIFT.
- Bits after completion with no sof are ignored (IDLE).
- Latency: if the buffer is empty, dvalid=1 on the cycle after the edge that sampled bit 0. dout/row are then stable until popped.
- Buffer: FIFO of DEPTH entries.
  - Push on word completion; pop on dvalid&&dready.
  - Push and pop in the same cycle:
    - When full: both succeed, occupancy unchanged, no overflow.
    - When empty: word is written; dvalid=1 next cycle (no bypass).
  - Push while full with no pop: word dropped; overflow<=1 and stays set until reset.
- dout/row/dvalid are registered outputs. dout and row show the head entry. dout and row are 0 after reset until the first push; otherwise they hold the last head value when the buffer is empty.
- Pointer wrap: log2(DEPTH) pointers plus an occupancy count of width log2(DEPTH)+1.

Optional Feature:
- Macro: SIPO_RX_ERRCNT_EN.
- Defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments on each frm_err pulse and on each dropped word; saturates at 255.
  - If both events occur in the same cycle, it increments by 2, still saturating.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic word: rst low 2 cycles; en=1 continuous; sof on first bit; send 75'h4_0000_0000_0000_0000_1 MSB first; dready=1 -> dvalid pulses 1 cycle after bit 0; dout=75'h4_0000_0000_0000_0000_1, row=1.
- Row wrap: five back-to-back frames -> rows 1,2,3,4,1; frm_err never set.
- Enable gaps: en toggles 1,0,0,1... across a frame of all-ones -> dout=all ones, busy=1 throughout, dvalid only after 75 en-qualified bits.
- Early sof: sof at bit 30 of a frame -> frm_err=1 for one cycle; first word never appears; next completed word has row=2.
- Backpressure/overflow: dready=0, three frames -> first two buffered, third dropped, overflow=1. Then dready=1 -> exactly two words out, in order. Also check push and pop in the same cycle while full: no overflow.
- Reset mid-frame and with buffered data: rst low at bit 40 with 1 word buffered -> dvalid=0, busy=0, row=0, overflow=0 next cycle. The next frame gets row=1. With SIPO_RX_ERRCNT_EN defined, err_cnt=0 after reset and equals 1 after a single early sof.

Source files
------------

// File: rtl/sipo_rx_if.sv
// rtl/sipo_rx_if.sv - serial input, buffered word output and status bundle for sipo_rx
// slave modport is the deserializer side; master is the upstream/consumer side.
interface sipo_rx_if #(
  parameter int WIDTH = 75
);
  logic             en;
  logic             sin;
  logic             sof;
  logic [WIDTH-1:0] dout;
  logic [2:0]       row;
  logic             dvalid;
  logic             dready;
  logic             busy;
  logic             overflow;
  logic             frm_err;

  modport master (
    output en, sin, sof, dready,
    input  dout, row, dvalid, busy, overflow, frm_err
  );

  modport slave (
    input  en, sin, sof, dready,
    output dout, row, dvalid, busy, overflow, frm_err
  );
endinterface

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - MSB-first deserializer with row tagging and a small valid/ready output FIFO
// Optional error counter output enabled by defining SIPO_RX_ERRCNT_EN.
module sipo_rx #(
  parameter int WIDTH = 75,
  parameter int ROWS  = 4,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  sipo_rx_if.slave   bus
`ifdef SIPO_RX_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_OCC = DEPTH[PW:0];
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [2:0]    ROW_MAX  = ROWS[2:0];

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       row_trk_q, row_trk_d;
  logic             frm_err_q, frm_err_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [2:0]       tag_q [DEPTH];
  logic [2:0]       tag_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      occ_q, occ_d;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [2:0]       row_q, row_d;
  logic             dvalid_q, dvalid_d;

  logic             push, pop, full, drop;
  logic [CW-1:0]    bit_idx;
  logic [2:0]       row_next;

  // Frame collection: bits land directly at their final position WIDTH-1-count.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    row_trk_d = row_trk_q;
    frm_err_d = 1'b0;
    push      = 1'b0;
    row_next  = (row_trk_q == ROW_MAX) ? 3'd1 : row_trk_q + 3'd1;
    bit_idx   = LAST_CNT - cnt_q;
    if (bus.en) begin
      if (bus.sof) begin
        frm_err_d          = (state_q == SHIFT);
        shreg_d            = '0;
        shreg_d[WIDTH-1]   = bus.sin;
        cnt_d              = CW'(1);
        row_trk_d          = row_next;
        state_d            = SHIFT;
      end else if (state_q == SHIFT) begin
        shreg_d[bit_idx] = bus.sin;
        cnt_d            = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  // Output FIFO; a push into a full buffer survives only if a pop frees a slot this cycle.
  always_comb begin
    mem_d      = mem_q;
    tag_d      = tag_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    full       = (occ_q == FULL_OCC);
    pop        = dvalid_q && bus.dready;
    drop       = push && full && !pop;
    overflow_d = overflow_q || drop;
    if (push && !drop) begin
      mem_d[wptr_q] = shreg_d;
      tag_d[wptr_q] = row_trk_q;
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if ((push && !drop) && !pop) begin
      occ_d = occ_q + (PW+1)'(1);
    end else if (!(push && !drop) && pop) begin
      occ_d = occ_q - (PW+1)'(1);
    end
    dvalid_d = (occ_d != '0);
    dout_d   = dvalid_d ? mem_d[rptr_d] : dout_q;
    row_d    = dvalid_d ? tag_d[rptr_d] : row_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      row_trk_q  <= '0;
      frm_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      dout_q     <= '0;
      row_q      <= '0;
      dvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      row_trk_q  <= row_trk_d;
      frm_err_q  <= frm_err_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      dout_q     <= dout_d;
      row_q      <= row_d;
      dvalid_q   <= dvalid_d;
    end
  end

  // Storage contents are don't-care until written; only pointers/occupancy need reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    tag_q <= tag_d;
  end

  assign bus.dout     = dout_q;
  assign bus.row      = row_q;
  assign bus.dvalid   = dvalid_q;
  assign bus.busy     = (state_q == SHIFT);
  assign bus.overflow = overflow_q;
  assign bus.frm_err  = frm_err_q;

`ifdef SIPO_RX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [8:0] err_sum;

  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + {8'd0, frm_err_d} + {8'd0, drop};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// tb/tb_sipo_rx.sv - directed, table-driven bench for sipo_rx
// Frame table covers basic word, row wrap and enable gaps; hand sequences cover the rest.
module tb_sipo_rx;
  localparam int W = 75;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_rx_if #(.WIDTH(W)) bus ();
`ifdef SIPO_RX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  sipo_rx #(.WIDTH(W), .ROWS(4), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SIPO_RX_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  typedef struct {
    logic [W-1:0] data;
    bit           gaps;
    logic [2:0]   exp_row;
  } vec_t;

  localparam logic [W-1:0] W_BASIC = 75'h4_0000_0000_0000_0000_1;
  localparam logic [W-1:0] W_ONES  = {W{1'b1}};
  localparam logic [W-1:0] W_A5    = 75'h5_A5A5_A5A5_A5A5_A5A5_A;
  localparam logic [W-1:0] W_ZERO  = '0;
  localparam logic [W-1:0] W_DEAD  = 75'h2_DEAD_BEEF_CAFE_F00D_5;

  int n_pass  = 0;
  int n_total = 0;
  vec_t vecs[5];
  bit pre_dv, busy_ok;
  int frm_cnt;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.en = 1'b0; bus.sof = 1'b0; bus.dready = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Sends the top nbits of word, sof on the first; gaps inserts two en=0 cycles after each bit.
  task automatic send_word(input logic [W-1:0] word, input int nbits, input bit gaps,
                           output bit pdv, output bit bok, output int fcnt);
    bok = 1'b1; fcnt = 0; pdv = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == nbits - 1) pdv = bus.dvalid;
      bus.en  = 1'b1;
      bus.sin = word[W-1-i];
      bus.sof = (i == 0);
      tick();
      if (bus.frm_err) fcnt++;
      if (i != W - 1 && !bus.busy) bok = 1'b0;
      if (gaps && i != nbits - 1) begin
        bus.en = 1'b0; bus.sof = 1'b0;
        repeat (2) begin
          tick();
          if (!bus.busy) bok = 1'b0;
        end
      end
    end
    bus.en = 1'b0; bus.sof = 1'b0;
  endtask

  task automatic pop_one();
    bus.dready = 1'b1;
    tick();
    bus.dready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{W_BASIC, 1'b0, 3'd1};
    vecs[1] = '{W_ONES,  1'b1, 3'd2};
    vecs[2] = '{W_A5,    1'b0, 3'd3};
    vecs[3] = '{W_ZERO,  1'b0, 3'd4};
    vecs[4] = '{W_DEAD,  1'b0, 3'd1};

    bus.en = 1'b0; bus.sin = 1'b0; bus.sof = 1'b0; bus.dready = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    check("rst_dout", bus.dout, '0);
    check("rst_row", bus.row, 0);
    check("rst_dvalid", bus.dvalid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_frm_err", bus.frm_err, 0);
`ifdef SIPO_RX_ERRCNT_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    rst = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].data, W, vecs[v].gaps, pre_dv, busy_ok, frm_cnt);
      check($sformatf("vec%0d_pre_dvalid", v), pre_dv, 0);
      check($sformatf("vec%0d_dvalid", v), bus.dvalid, 1);
      check($sformatf("vec%0d_dout", v), bus.dout, vecs[v].data);
      check($sformatf("vec%0d_row", v), bus.row, vecs[v].exp_row);
      check($sformatf("vec%0d_busy_held", v), busy_ok, 1);
      check($sformatf("vec%0d_busy_done", v), bus.busy, 0);
      check($sformatf("vec%0d_no_frm_err", v), frm_cnt, 0);
      pop_one();
      check($sformatf("vec%0d_popped", v), bus.dvalid, 0);
    end

    // Early sof: abort at bit 30, restart with a new tag
    do_reset();
    send_word(W_A5, 30, 1'b0, pre_dv, busy_ok, frm_cnt);
    check("early_first_no_err", frm_cnt, 0);
    send_word(W_DEAD, W, 1'b0, pre_dv, busy_ok, frm_cnt);
    check("early_frm_err_pulses", frm_cnt, 1);
    check("early_no_first_word", pre_dv, 0);
    check("early_dvalid", bus.dvalid, 1);
    check("early_dout", bus.dout, W_DEAD);
    check("early_row", bus.row, 2);
`ifdef SIPO_RX_ERRCNT_EN
    check("early_err_cnt", err_cnt, 1);
`endif
    pop_one();

    // Backpressure: third word dropped, first two drain in order
    do_reset();
    send_word(W_BASIC, W, 1'b0, pre_dv, busy_ok, frm_cnt);
    send_word(W_A5, W, 1'b0, pre_dv, busy_ok, frm_cnt);
    check("bp_full_no_ovf", bus.overflow, 0);
    send_word(W_DEAD, W, 1'b0, pre_dv, busy_ok, frm_cnt);
    check("bp_overflow", bus.overflow, 1);
    check("bp_head_dout", bus.dout, W_BASIC);
    check("bp_head_row", bus.row, 1);
`ifdef SIPO_RX_ERRCNT_EN
    check("bp_err_cnt", err_cnt, 1);
`endif
    pop_one();
    check("bp_second_dvalid", bus.dvalid, 1);
    check("bp_second_dout", bus.dout, W_A5);
    check("bp_second_row", bus.row, 2);
    pop_one();
    check("bp_drained", bus.dvalid, 0);
    check("bp_ovf_sticky", bus.overflow, 1);

    // Push and pop on the same edge while full
    do_reset();
    send_word(W_BASIC, W, 1'b0, pre_dv, busy_ok, frm_cnt);
    send_word(W_A5, W, 1'b0, pre_dv, busy_ok, frm_cnt);
    send_word(W_ONES, W - 1, 1'b0, pre_dv, busy_ok, frm_cnt);
    bus.en = 1'b1; bus.sof = 1'b0; bus.sin = W_ONES[0]; bus.dready = 1'b1;
    tick();
    bus.en = 1'b0; bus.dready = 1'b0;
    check("pp_no_overflow", bus.overflow, 0);
    check("pp_head_dout", bus.dout, W_A5);
    check("pp_head_row", bus.row, 2);
    pop_one();
    check("pp_third_dout", bus.dout, W_ONES);
    check("pp_third_row", bus.row, 3);
    pop_one();
    check("pp_drained", bus.dvalid, 0);

    // Reset mid-frame with a buffered word
    do_reset();
    send_word(W_A5, W, 1'b0, pre_dv, busy_ok, frm_cnt);
    send_word(W_DEAD, 40, 1'b0, pre_dv, busy_ok, frm_cnt);
    rst = 1'b0;
    tick();
    check("mid_rst_dvalid", bus.dvalid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_row", bus.row, 0);
    check("mid_rst_overflow", bus.overflow, 0);
    check("mid_rst_dout", bus.dout, '0);
`ifdef SIPO_RX_ERRCNT_EN
    check("mid_rst_err_cnt", err_cnt, 0);
`endif
    rst = 1'b1;
    send_word(W_BASIC, W, 1'b0, pre_dv, busy_ok, frm_cnt);
    check("post_rst_dvalid", bus.dvalid, 1);
    check("post_rst_dout", bus.dout, W_BASIC);
    check("post_rst_row", bus.row, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
